// File: rtl/fx2_reg_cmd_responder_if.sv
// Byte streams and register-bus signals of the FX2 command responder.
// master = responder side, slave = FIFO/register-file side.
interface fx2_reg_cmd_responder_if;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  reply_data;
    logic        reply_valid;
    logic        reply_ready;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_req;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (
        input  cmd_data, cmd_valid, reply_ready, reg_rdata, reg_ack,
        output cmd_ready, reply_data, reply_valid, reg_addr, reg_wdata, reg_wr, reg_req
    );

    modport slave (
        output cmd_data, cmd_valid, reply_ready, reg_rdata, reg_ack,
        input  cmd_ready, reply_data, reply_valid, reg_addr, reg_wdata, reg_wr, reg_req
    );
endinterface

// File: rtl/fx2_reg_cmd_responder.sv
// Parses 8-byte host register commands from the FX2 OUT stream, runs one register-bus
// transaction and returns the 32-bit result as a 4-byte little-endian reply.
module fx2_reg_cmd_responder #(
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned BYTE_TIMEOUT = 4096,
    parameter logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF
) (
    input  logic                    clk,
    input  logic                    reset,
    fx2_reg_cmd_responder_if.master bus,
    output logic                    busy,
    output logic [7:0]              err_count
);
    localparam int unsigned BtW = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned AtW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [BtW-1:0] BtLast = BtW'(BYTE_TIMEOUT - 1);
    localparam logic [AtW-1:0] AtLast = AtW'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StHunt, StFlag, StAddr0, StAddr1, StVal0, StVal1, StVal2, StVal3, StBus, StReply
    } state_e;

    state_e         r_state, w_state_nxt;
    logic           r_flag, w_flag_nxt;
    logic [15:0]    r_addr, w_addr_nxt;
    logic [31:0]    r_wdata, w_wdata_nxt;
    logic [31:0]    r_word, w_word_nxt;
    logic [1:0]     r_idx, w_idx_nxt;
    logic [BtW-1:0] r_byte_tmr, w_byte_tmr_nxt;
    logic [AtW-1:0] r_ack_tmr, w_ack_tmr_nxt;
    logic [7:0]     r_err;
    logic           w_err_inc;
    logic           w_in_frame;
    logic           w_cmd_fire;
    logic           w_rep_fire;

    assign w_in_frame = (r_state != StHunt) && (r_state != StBus) && (r_state != StReply);
    assign w_cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign w_rep_fire = bus.reply_valid && bus.reply_ready;

    assign bus.cmd_ready   = (r_state != StBus) && (r_state != StReply);
    assign bus.reg_req     = (r_state == StBus);
    assign bus.reg_wr      = (r_state == StBus) && r_flag;
    assign bus.reg_addr    = r_addr;
    assign bus.reg_wdata   = r_wdata;
    assign bus.reply_valid = (r_state == StReply);
    assign bus.reply_data  = (r_state == StReply) ? r_word[{r_idx, 3'b000} +: 8] : 8'h00;
    assign busy            = (r_state != StHunt);
    assign err_count       = r_err;

    always_comb begin
        w_state_nxt    = r_state;
        w_flag_nxt     = r_flag;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_word_nxt     = r_word;
        w_idx_nxt      = r_idx;
        w_byte_tmr_nxt = r_byte_tmr;
        w_ack_tmr_nxt  = r_ack_tmr;
        w_err_inc      = 1'b0;

        // Inter-byte watchdog; an accepted byte on the expiry edge takes priority.
        if (w_in_frame) begin
            if (w_cmd_fire) begin
                w_byte_tmr_nxt = '0;
            end else if (r_byte_tmr == BtLast) begin
                w_byte_tmr_nxt = '0;
                w_state_nxt    = StHunt;
                w_err_inc      = 1'b1;
            end else begin
                w_byte_tmr_nxt = r_byte_tmr + BtW'(1);
            end
        end

        case (r_state)
            StHunt: begin
                if (w_cmd_fire && bus.cmd_data == 8'hAA) begin
                    w_state_nxt    = StFlag;
                    w_byte_tmr_nxt = '0;
                end
            end
            StFlag: begin
                if (w_cmd_fire) begin
                    if (bus.cmd_data[7:1] == 7'd0) begin
                        w_flag_nxt  = bus.cmd_data[0];
                        w_state_nxt = StAddr0;
                    end else if (bus.cmd_data != 8'hAA) begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = StHunt;
                    end
                end
            end
            StAddr0: if (w_cmd_fire) begin
                w_addr_nxt[7:0] = bus.cmd_data;
                w_state_nxt     = StAddr1;
            end
            StAddr1: if (w_cmd_fire) begin
                w_addr_nxt[15:8] = bus.cmd_data;
                w_state_nxt      = StVal0;
            end
            StVal0: if (w_cmd_fire) begin
                w_wdata_nxt[7:0] = bus.cmd_data;
                w_state_nxt      = StVal1;
            end
            StVal1: if (w_cmd_fire) begin
                w_wdata_nxt[15:8] = bus.cmd_data;
                w_state_nxt       = StVal2;
            end
            StVal2: if (w_cmd_fire) begin
                w_wdata_nxt[23:16] = bus.cmd_data;
                w_state_nxt        = StVal3;
            end
            StVal3: if (w_cmd_fire) begin
                w_wdata_nxt[31:24] = bus.cmd_data;
                w_ack_tmr_nxt      = '0;
                w_state_nxt        = StBus;
            end
            StBus: begin
                // An ack on the timeout edge still completes the transaction normally.
                if (bus.reg_ack) begin
                    w_word_nxt  = bus.reg_rdata;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = StReply;
                end else if (r_ack_tmr == AtLast) begin
                    w_word_nxt  = TIMEOUT_WORD;
                    w_idx_nxt   = 2'd0;
                    w_err_inc   = 1'b1;
                    w_state_nxt = StReply;
                end else begin
                    w_ack_tmr_nxt = r_ack_tmr + AtW'(1);
                end
            end
            StReply: begin
                if (w_rep_fire) begin
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = StHunt;
                    end
                end
            end
            default: w_state_nxt = StHunt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StHunt;
            r_flag     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
            r_idx      <= '0;
            r_byte_tmr <= '0;
            r_ack_tmr  <= '0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_flag     <= w_flag_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_word     <= w_word_nxt;
            r_idx      <= w_idx_nxt;
            r_byte_tmr <= w_byte_tmr_nxt;
            r_ack_tmr  <= w_ack_tmr_nxt;
            if (w_err_inc && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_fx2_reg_cmd_responder.sv
// Self-checking bench for fx2_reg_cmd_responder: directed protocol scenarios plus randomized
// frames checked against a byte-level protocol model and a register-file slave.
module tb_fx2_reg_cmd_responder;
    localparam int unsigned AckTo  = 64;
    localparam int unsigned ByteTo = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [7:0] err_count;
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_err = 0;

    fx2_reg_cmd_responder_if ifc ();

    fx2_reg_cmd_responder #(
        .ACK_TIMEOUT (AckTo),
        .BYTE_TIMEOUT(ByteTo),
        .TIMEOUT_WORD(32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (ifc.master),
        .busy     (busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Register-file slave: acks on the ack_delay-th request cycle (0 = never).
    int          ack_delay = 1;
    bit          ack_noise = 1'b0;
    int          bus_cyc = 0;
    int          req_cyc = 0;
    bit          unstable = 1'b0;
    logic        cap_wr;
    logic [15:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] mem [logic [15:0]];

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : {16'hC0DE, a};
    endfunction

    always @(negedge clk) begin
        if (ifc.reg_req) begin
            if (bus_cyc == 0) begin
                cap_wr    = ifc.reg_wr;
                cap_addr  = ifc.reg_addr;
                cap_wdata = ifc.reg_wdata;
            end else if (ifc.reg_wr !== cap_wr || ifc.reg_addr !== cap_addr ||
                         ifc.reg_wdata !== cap_wdata) begin
                unstable = 1'b1;
            end
            bus_cyc++;
            req_cyc       = bus_cyc;
            ifc.reg_ack   = (ack_delay != 0) && (bus_cyc == ack_delay);
            ifc.reg_rdata = cap_wr ? cap_wdata : mem_rd(cap_addr);
            if (ifc.reg_ack && cap_wr) mem[cap_addr] = cap_wdata;
        end else begin
            bus_cyc       = 0;
            ifc.reg_ack   = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            ifc.reg_rdata = $urandom;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "simulation time limit");
    end

    // All stimulus tasks are entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        ifc.cmd_data  = b;
        ifc.cmd_valid = 1'b1;
        while (!ifc.cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 500) begin
            n_errors++;
            $display("FAIL cmd_ready_wait: cmd_ready=%0b required 1", ifc.cmd_ready);
        end
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: toggling ready, 2: random ready
    task automatic collect_reply(input int mode, input int nbytes,
                                 output logic [31:0] word, output int got);
        logic [7:0] held = 8'h00;
        bit         stalled = 1'b0;
        int         t = 0;
        got  = 0;
        word = '0;
        while (got < nbytes && t < 400) begin
            ifc.reply_ready = (mode == 0) ? 1'b1 : (mode == 1) ? t[0] : 1'($urandom_range(0, 1));
            if (ifc.reply_valid) begin
                if (stalled) begin
                    n_checks++;
                    if (ifc.reply_data !== held) begin
                        n_errors++;
                        $display("FAIL reply_hold: data %02h required %02h", ifc.reply_data, held);
                    end
                end
                if (ifc.reply_ready) begin
                    word[8*got +: 8] = ifc.reply_data;
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = ifc.reply_data;
                end
            end
            @(negedge clk);
            t++;
        end
        ifc.reply_ready = 1'b0;
    endtask

    task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [31:0] val,
                          input int ack_dly, input int mode, input int gap_max, input int nbytes,
                          output logic [31:0] word, output int got);
        logic [7:0] fr [8];
        fr[0] = 8'hAA;
        fr[1] = {7'd0, wr};
        fr[2] = addr[7:0];
        fr[3] = addr[15:8];
        for (int i = 0; i < 4; i++) fr[4+i] = val[8*i +: 8];
        ack_delay = ack_dly;
        req_cyc   = 0;
        unstable  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_byte(fr[i]);
        end
        collect_reply(mode, nbytes, word, got);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ifc.reg_req, ifc.reg_wr, ifc.reply_valid, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: req/wr/rvalid/busy=%b required 0000",
                     {ifc.reg_req, ifc.reg_wr, ifc.reply_valid, busy});
        end
        n_checks++;
        if (ifc.reg_addr !== 16'h0 || ifc.reg_wdata !== 32'h0 || ifc.reply_data !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0", ifc.reg_addr,
                     ifc.reg_wdata, ifc.reply_data);
        end
        n_checks++;
        if (err_count !== 8'd0 || ifc.cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_status: err=%0d cmd_ready=%0b required 0/1", err_count,
                     ifc.cmd_ready);
        end
    endtask

    task automatic test_garbage_read();
        logic [31:0] word;
        int          got;
        mem[16'h0001] = 32'h0000_0002;
        repeat (3) send_byte(8'hFF);
        n_checks++;
        if (busy !== 1'b0 || err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL garbage_drop: busy=%0b err=%0d required 0/0", busy, err_count);
        end
        do_txn(1'b0, 16'h0001, 32'h0, 1, 0, 0, 4, word, got);
        n_checks++;
        if (got !== 4 || word !== 32'h0000_0002) begin
            n_errors++;
            $display("FAIL read_reply: got %0d bytes word=%h required 4/00000002", got, word);
        end
        n_checks++;
        if (req_cyc !== 1 || cap_wr !== 1'b0 || cap_addr !== 16'h0001) begin
            n_errors++;
            $display("FAIL read_bus: req_cycles=%0d wr=%0b addr=%h required 1/0/0001", req_cyc,
                     cap_wr, cap_addr);
        end
        n_checks++;
        if (ifc.reply_valid !== 1'b0 || busy !== 1'b0 || err_count !== 8'(exp_err)) begin
            n_errors++;
            $display("FAIL read_end: rvalid=%0b busy=%0b err=%0d required 0/0/%0d",
                     ifc.reply_valid, busy, err_count, exp_err);
        end
    endtask

    task automatic test_write();
        logic [31:0] word;
        int          got;
        do_txn(1'b1, 16'h0003, 32'h0000_0004, 3, 0, 0, 4, word, got);
        n_checks++;
        if (got !== 4 || word !== 32'h0000_0004) begin
            n_errors++;
            $display("FAIL write_reply: got %0d bytes word=%h required 4/00000004", got, word);
        end
        n_checks++;
        if (req_cyc !== 3 || cap_wr !== 1'b1 || cap_addr !== 16'h0003 ||
            cap_wdata !== 32'h4 || unstable) begin
            n_errors++;
            $display("FAIL write_bus: req_cycles=%0d wr=%0b addr=%h wdata=%h unstable=%0b required 3/1/0003/00000004/0",
                     req_cyc, cap_wr, cap_addr, cap_wdata, unstable);
        end
    endtask

    task automatic test_bad_flag();
        logic [31:0] word;
        int          got;
        send_byte(8'hAA);
        send_byte(8'h05);
        if (exp_err < 255) exp_err++;
        n_checks++;
        if (err_count !== 8'(exp_err) || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_flag: err=%0d busy=%0b required %0d/0", err_count, busy, exp_err);
        end
        send_byte(8'hAA);
        do_txn(1'b0, 16'h0002, 32'h0, 2, 0, 0, 4, word, got);
        n_checks++;
        if (got !== 4 || word !== mem_rd(16'h0002) || cap_addr !== 16'h0002 ||
            err_count !== 8'(exp_err)) begin
            n_errors++;
            $display("FAIL resync_read: got %0d word=%h addr=%h err=%0d required 4/%h/0002/%0d",
                     got, word, cap_addr, err_count, mem_rd(16'h0002), exp_err);
        end
    endtask

    task automatic test_ack_timeout();
        logic [31:0] word;
        int          got;
        do_txn(1'b1, 16'h0028, $urandom, 0, 0, 0, 4, word, got);
        if (exp_err < 255) exp_err++;
        n_checks++;
        if (got !== 4 || word !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL timeout_reply: got %0d word=%h required 4/deadbeef", got, word);
        end
        n_checks++;
        if (req_cyc !== AckTo || err_count !== 8'(exp_err)) begin
            n_errors++;
            $display("FAIL timeout_bus: req_cycles=%0d err=%0d required %0d/%0d", req_cyc,
                     err_count, AckTo, exp_err);
        end
    endtask

    task automatic test_byte_stall();
        logic [31:0] word;
        int          got;
        req_cyc = 0;
        send_byte(8'hAA);
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (ByteTo - 1) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_early: busy=%0b required 1", busy);
        end
        @(negedge clk);
        if (exp_err < 255) exp_err++;
        n_checks++;
        if (busy !== 1'b0 || err_count !== 8'(exp_err) || req_cyc !== 0) begin
            n_errors++;
            $display("FAIL stall_abort: busy=%0b err=%0d req_cycles=%0d required 0/%0d/0", busy,
                     err_count, req_cyc, exp_err);
        end
        // A byte arriving on the expiry edge keeps the frame alive.
        ack_delay = 2;
        send_byte(8'hAA);
        send_byte(8'h00);
        send_byte(8'h05);
        repeat (ByteTo - 1) @(negedge clk);
        repeat (5) send_byte(8'h00);
        collect_reply(0, 4, word, got);
        n_checks++;
        if (got !== 4 || word !== mem_rd(16'h0005) || req_cyc !== 2 ||
            err_count !== 8'(exp_err)) begin
            n_errors++;
            $display("FAIL stall_edge: got %0d word=%h req_cycles=%0d err=%0d required 4/%h/2/%0d",
                     got, word, req_cyc, err_count, mem_rd(16'h0005), exp_err);
        end
    endtask

    task automatic test_random();
        logic [31:0] word, exp_word, val;
        logic [15:0] addr;
        logic [7:0]  g;
        bit          wr;
        int          got, dly;
        ack_noise = 1'b1;
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hAA) g = 8'h55;
                send_byte(g);
            end
            wr       = 1'($urandom_range(0, 1));
            addr     = 16'($urandom);
            val      = $urandom;
            dly      = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            exp_word = (dly == 0) ? 32'hDEADBEEF : (wr ? val : mem_rd(addr));
            if (dly == 0 && exp_err < 255) exp_err++;
            do_txn(wr, addr, val, dly, 2, 3, 4, word, got);
            n_checks++;
            if (got !== 4 || word !== exp_word) begin
                n_errors++;
                $display("FAIL rand_reply[%0d]: got %0d word=%h required 4/%h", i, got, word,
                         exp_word);
            end
            n_checks++;
            if (req_cyc !== ((dly == 0) ? AckTo : dly) || cap_wr !== wr || cap_addr !== addr ||
                cap_wdata !== val || unstable) begin
                n_errors++;
                $display("FAIL rand_bus[%0d]: cyc=%0d wr=%0b addr=%h wdata=%h unstable=%0b required %0d/%0b/%h/%h/0",
                         i, req_cyc, cap_wr, cap_addr, cap_wdata, unstable,
                         (dly == 0) ? AckTo : dly, wr, addr, val);
            end
            n_checks++;
            if (err_count !== 8'(exp_err)) begin
                n_errors++;
                $display("FAIL rand_err[%0d]: err=%0d required %0d", i, err_count, exp_err);
            end
        end
        ack_noise = 1'b0;
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hAA);
            send_byte(8'h07);
            if (exp_err < 255) exp_err++;
        end
        n_checks++;
        if (err_count !== 8'(exp_err) || err_count !== 8'd255) begin
            n_errors++;
            $display("FAIL err_saturate: err=%0d required 255", err_count);
        end
    endtask

    task automatic test_backpressure_reset();
        logic [31:0] word, v;
        int          got;
        v = $urandom;
        mem[16'h0010] = v;
        do_txn(1'b0, 16'h0010, 32'h0, 1, 1, 0, 4, word, got);
        n_checks++;
        if (got !== 4 || word !== v) begin
            n_errors++;
            $display("FAIL toggle_reply: got %0d word=%h required 4/%h", got, word, v);
        end
        do_txn(1'b0, 16'h0010, 32'h0, 2, 1, 0, 2, word, got);
        n_checks++;
        if (got !== 2 || word[15:0] !== v[15:0] || ifc.reply_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL partial_reply: got %0d low=%h rvalid=%0b required 2/%h/1", got,
                     word[15:0], ifc.reply_valid, v[15:0]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_err = 0;
        n_checks++;
        if ({ifc.reply_valid, busy, ifc.reg_req, ifc.cmd_ready} !== 4'b0001 ||
            err_count !== 8'd0 || ifc.reply_data !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reply_reset: rvalid/busy/req/cmd_ready=%b err=%0d data=%h required 0001/0/00",
                     {ifc.reply_valid, busy, ifc.reg_req, ifc.cmd_ready}, err_count,
                     ifc.reply_data);
        end
        do_txn(1'b1, 16'h0011, 32'hA5A5_0F0F, 1, 2, 1, 4, word, got);
        n_checks++;
        if (got !== 4 || word !== 32'hA5A5_0F0F || err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL post_reset: got %0d word=%h err=%0d required 4/a5a50f0f/0", got,
                     word, err_count);
        end
    endtask

    initial begin
        ifc.cmd_data    = 8'h00;
        ifc.cmd_valid   = 1'b0;
        ifc.reply_ready = 1'b0;
        test_reset();
        test_garbage_read();
        test_write();
        test_bad_flag();
        test_ack_timeout();
        test_byte_stall();
        test_random();
        test_err_saturate();
        test_backpressure_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
